cory_unpack_seq: RTL and testbench

Sequencer that accepts one packed word of R lanes (N bits each) with a per-word lane-enable mask. It issues the enabled lanes one at a time, lowest index first, on a single N-bit valid/ready output. Each beat carries its lane index and a last flag. It serves narrow consumers that cannot take R parallel lane outputs, and it drops disabled lanes without spending a cycle on them.

---
 rtl/cory_unpack_seq_pkg.sv | 26 ++
 rtl/cory_lsb_enc.sv | 26 ++
 rtl/cory_unpack_seq.sv | 87 ++++++++
 tb/tb_cory_unpack_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cory_unpack_seq_pkg.sv
// Shared constants and helpers for the cory lane sequencer and its encoder.
// Pure declarations; no logic, no latency, no flow control.
`ifndef CORY_UNPACK_SEQ_PKG_SV
`define CORY_UNPACK_SEQ_PKG_SV

package cory_unpack_seq_pkg;

  localparam int CORY_UNPACK_SEQ_RMAX = 16;
  localparam int CORY_UNPACK_SEQ_RMIN = 2;

  // Ceiling log2 with clog2(1) = 0; evaluated at elaboration time.
  function automatic int clog2(input int value);
    int result;
    int acc;
    result = 0;
    acc    = 1;
    while (acc < value) begin
      acc    = acc * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

`endif

// File: rtl/cory_lsb_enc.sv
// Lowest-set-bit priority encoder: index, any-set flag and one-hot of the winner.
// Latency: purely combinational. Backpressure: none, no handshake.
module cory_lsb_enc #(
  parameter int W  = 4,
  parameter int IW = 2
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic [W-1:0]  onehot
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = vec & (~vec + W'(1));
  assign any    = |vec;

  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cory_unpack_seq.sv
// Serialises the enabled lanes of one packed word, lowest index first, with idx/last tags.
// Latency: first lane one cycle after acceptance, then one lane per cycle.
// Backpressure: outputs hold while i_z_r is low; o_a_r opens on the last beat for zero-bubble reload.
module cory_unpack_seq
  import cory_unpack_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int R  = 4,
  parameter int A  = N * R,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_a_v,
  input  logic [A-1:0]  i_a_d,
  input  logic [R-1:0]  i_a_m,
  output logic          o_a_r,
  output logic          o_z_v,
  output logic [N-1:0]  o_z_d,
  output logic [IW-1:0] o_z_idx,
  output logic          o_z_last,
  input  logic          i_z_r,
  output logic          o_busy
);

  generate
    if (R < CORY_UNPACK_SEQ_RMIN || R > CORY_UNPACK_SEQ_RMAX || IW < clog2(R) || A != N * R)
    begin : g_bad_param
      $error("cory_unpack_seq: illegal parameters N=%0d R=%0d A=%0d IW=%0d", N, R, A, IW);
    end
  endgenerate

  logic [A-1:0]  word_q;
  logic [R-1:0]  rem_q;
  logic [IW-1:0] sel_idx;
  logic          sel_any;
  logic [R-1:0]  sel_onehot;
  logic          busy;
  logic          accept;
  logic          beat_done;
  logic [N-1:0]  lane_mux;

  cory_lsb_enc #(
    .W  (R),
    .IW (IW)
  ) u_enc (
    .vec    (rem_q),
    .idx    (sel_idx),
    .any    (sel_any),
    .onehot (sel_onehot)
  );

  assign busy = sel_any;

  // Last when nothing remains once the selected bit is removed.
  assign o_z_last  = busy && ((rem_q & ~sel_onehot) == '0);
  assign o_z_v     = busy;
  assign o_busy    = busy;
  assign o_a_r     = !busy || (i_z_r && o_z_last);
  assign o_z_idx   = busy ? sel_idx : '0;
  assign accept    = i_a_v && o_a_r;
  assign beat_done = o_z_v && i_z_r;

  // One-hot AND-OR mux; an empty mask yields zero data for free.
  always_comb begin
    lane_mux = '0;
    for (int k = 0; k < R; k++) begin
      lane_mux = lane_mux | ({N{sel_onehot[k]}} & word_q[k*N +: N]);
    end
  end

  assign o_z_d = lane_mux;

  // A new word outranks clearing the final lane of the previous one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      word_q <= i_a_d;
      rem_q  <= i_a_m;
    end else if (beat_done) begin
      rem_q  <= rem_q & ~sel_onehot;
    end
  end

endmodule

// File: tb/tb_cory_unpack_seq.sv
// Directed bench for cory_unpack_seq: every beat is checked as {v, data, idx, last, a_r}.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_cory_unpack_seq;

  localparam int N  = 8;
  localparam int R  = 4;
  localparam int A  = N * R;
  localparam int IW = 4;

  logic          clk;
  logic          reset_n;
  logic          i_a_v;
  logic [A-1:0]  i_a_d;
  logic [R-1:0]  i_a_m;
  logic          o_a_r;
  logic          o_z_v;
  logic [N-1:0]  o_z_d;
  logic [IW-1:0] o_z_idx;
  logic          o_z_last;
  logic          i_z_r;
  logic          o_busy;

  int checks = 0;
  int errors = 0;

  cory_unpack_seq #(
    .N  (N),
    .R  (R),
    .A  (A),
    .IW (IW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_a_v    (i_a_v),
    .i_a_d    (i_a_d),
    .i_a_m    (i_a_m),
    .o_a_r    (o_a_r),
    .o_z_v    (o_z_v),
    .o_z_d    (o_z_d),
    .o_z_idx  (o_z_idx),
    .o_z_last (o_z_last),
    .i_z_r    (i_z_r),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed view, packed as {v, d[7:0], idx[3:0], last, a_r}.
  logic [14:0] obs;
  assign obs = {o_z_v, o_z_d, o_z_idx, o_z_last, o_a_r};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_a_v   = 1'b0;
    i_a_d   = '0;
    i_a_m   = '0;
    i_z_r   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({obs, o_busy} !== {15'b0_00000000_0000_0_1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h busy %b, expected %h busy 0", obs, o_busy, 15'b0_00000000_0000_0_1);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (obs !== 15'b0_00000000_0000_0_1) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected %h", obs, 15'b0_00000000_0000_0_1);
    end
  endtask

  task automatic test_full_mask();
    logic [14:0] exp_beats [4];
    exp_beats[0] = {1'b1, 8'hAA, 4'd0, 1'b0, 1'b0};
    exp_beats[1] = {1'b1, 8'hBB, 4'd1, 1'b0, 1'b0};
    exp_beats[2] = {1'b1, 8'hCC, 4'd2, 1'b0, 1'b0};
    exp_beats[3] = {1'b1, 8'hDD, 4'd3, 1'b1, 1'b1};
    i_z_r = 1'b1;
    i_a_d = 32'hDDCCBBAA;
    i_a_m = 4'b1111;
    i_a_v = 1'b1;
    step();
    i_a_v = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (obs !== exp_beats[b]) begin
        errors++;
        $display("FAIL full_mask_beat%0d: got %h expected %h", b, obs, exp_beats[b]);
      end
      step();
    end
    checks++;
    if ({obs, o_busy} !== {15'b0_00000000_0000_0_1, 1'b0}) begin
      errors++;
      $display("FAIL full_mask_idle: got %h busy %b", obs, o_busy);
    end
  endtask

  task automatic test_sparse();
    i_a_d = 32'h44332211;
    i_a_m = 4'b1010;
    i_a_v = 1'b1;
    step();
    i_a_v = 1'b0;
    checks++;
    if (obs !== {1'b1, 8'h22, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sparse_beat0: got %h expected %h", obs, {1'b1, 8'h22, 4'd1, 1'b0, 1'b0});
    end
    step();
    checks++;
    if (obs !== {1'b1, 8'h44, 4'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sparse_beat1: got %h expected %h", obs, {1'b1, 8'h44, 4'd3, 1'b1, 1'b1});
    end
    step();
    checks++;
    if (obs !== 15'b0_00000000_0000_0_1) begin
      errors++;
      $display("FAIL sparse_idle: got %h expected idle", obs);
    end
  endtask

  task automatic test_zero_mask();
    i_a_d = 32'hFFFFFFFF;
    i_a_m = 4'b0000;
    i_a_v = 1'b1;
    step();
    checks++;
    if ({obs, o_busy} !== {15'b0_00000000_0000_0_1, 1'b0}) begin
      errors++;
      $display("FAIL zero_mask_drop: got %h busy %b, expected idle and ready", obs, o_busy);
    end
    i_a_d = 32'h000000EE;
    i_a_m = 4'b0001;
    step();
    i_a_v = 1'b0;
    checks++;
    if (obs !== {1'b1, 8'hEE, 4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL zero_mask_next: got %h expected %h", obs, {1'b1, 8'hEE, 4'd0, 1'b1, 1'b1});
    end
    step();
    checks++;
    if (obs !== 15'b0_00000000_0000_0_1) begin
      errors++;
      $display("FAIL zero_mask_idle: got %h expected idle", obs);
    end
  endtask

  task automatic test_backpressure();
    i_z_r = 1'b0;
    i_a_d = 32'h44332211;
    i_a_m = 4'b0110;
    i_a_v = 1'b1;
    step();
    // A competing word is offered during the stall and must not be taken.
    i_a_d = 32'h99999999;
    i_a_m = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (obs !== {1'b1, 8'h22, 4'd1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_cycle%0d: got %h expected %h", c, obs, {1'b1, 8'h22, 4'd1, 1'b0, 1'b0});
      end
      step();
    end
    i_a_v = 1'b0;
    i_z_r = 1'b1;
    #1;
    checks++;
    if (obs !== {1'b1, 8'h22, 4'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL stall_release_lane1: got %h expected %h", obs, {1'b1, 8'h22, 4'd1, 1'b0, 1'b0});
    end
    step();
    checks++;
    if (obs !== {1'b1, 8'h33, 4'd2, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL stall_release_lane2: got %h expected %h", obs, {1'b1, 8'h33, 4'd2, 1'b1, 1'b1});
    end
    step();
    checks++;
    if (obs !== 15'b0_00000000_0000_0_1) begin
      errors++;
      $display("FAIL stall_idle: got %h expected idle", obs);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp_beats [4];
    exp_beats[0] = {1'b1, 8'hDD, 4'd0, 1'b0, 1'b0};
    exp_beats[1] = {1'b1, 8'hCC, 4'd1, 1'b1, 1'b1};
    exp_beats[2] = {1'b1, 8'h44, 4'd0, 1'b0, 1'b0};
    exp_beats[3] = {1'b1, 8'h33, 4'd1, 1'b1, 1'b1};
    i_z_r = 1'b1;
    i_a_d = 32'hAABBCCDD;
    i_a_m = 4'b0011;
    i_a_v = 1'b1;
    step();
    i_a_d = 32'h11223344;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (obs !== exp_beats[b]) begin
        errors++;
        $display("FAIL b2b_beat%0d: got %h expected %h", b, obs, exp_beats[b]);
      end
      step();
      if (b == 1) i_a_v = 1'b0;
    end
    checks++;
    if (obs !== 15'b0_00000000_0000_0_1) begin
      errors++;
      $display("FAIL b2b_idle: got %h expected idle", obs);
    end
  endtask

  task automatic test_reset_mid_word();
    i_z_r = 1'b1;
    i_a_d = 32'hDDCCBBAA;
    i_a_m = 4'b1111;
    i_a_v = 1'b1;
    step();
    i_a_v = 1'b0;
    step();
    step();
    // Two beats consumed; lane 2 is now on the output.
    checks++;
    if (obs !== {1'b1, 8'hCC, 4'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_pre: got %h expected %h", obs, {1'b1, 8'hCC, 4'd2, 1'b0, 1'b0});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({o_z_v, o_a_r, o_busy} !== 3'b010) begin
      errors++;
      $display("FAIL midreset_async: got v/a_r/busy %b expected 010", {o_z_v, o_a_r, o_busy});
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    step();
    checks++;
    if (obs !== 15'b0_00000000_0000_0_1) begin
      errors++;
      $display("FAIL midreset_release_idle: got %h expected idle", obs);
    end
    i_a_d = 32'h77665544;
    i_a_m = 4'b1000;
    i_a_v = 1'b1;
    step();
    i_a_v = 1'b0;
    checks++;
    if (obs !== {1'b1, 8'h77, 4'd3, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL midreset_new_word: got %h expected %h", obs, {1'b1, 8'h77, 4'd3, 1'b1, 1'b1});
    end
    step();
    checks++;
    if (obs !== 15'b0_00000000_0000_0_1) begin
      errors++;
      $display("FAIL midreset_final_idle: got %h expected idle", obs);
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse();
    test_zero_mask();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
